multicycle_ctrl_fsm: RTL

//  Multi-cycle RV32I control sequencer. It steps one instruction through

---
 rtl/multicycle_ctrl_fsm.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Control sequencer for a multi-cycle RV32I datapath. Each instruction is
//   stepped through FETCH / DECODE / EXECUTE / MEM / WB states. The block drives:
//     - the shared ALU operand muxes and the ALU op,
//     - the single memory port (request, write enable, address select),
//     - the IR / PC / register-file write enables,
//     - the immediate extender select (imm_src).
//   An unsupported opcode, or an unsupported branch funct3, parks the sequencer
//   in TRAP. Only reset leaves TRAP.
//
// Ports
//   i_clk          clock; all state changes happen on the rising edge
//   i_rst          synchronous, active-high reset
//   i_instr[31:0]  IR contents (opcode and funct3 are used)
//   i_zero         ALU zero flag from the rs1-rs2 compare
//   i_mem_ready    memory accepted/completed the request this cycle
//   o_mem_req      memory request (fetch, load or store)
//   o_mem_we       store strobe, qualified by o_mem_req
//   o_adr_src      memory address select: 0 PC, 1 ALUOut
//   o_ir_write     load IR and oldPC from the fetched word
//   o_pc_write     PC <= selected result
//   o_reg_write    write rd
//   o_imm_src      immediate select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 jalr
//   o_alu_src_a    00 PC, 01 oldPC, 10 rs1, 11 zero
//   o_alu_src_b    00 rs2, 01 ImmExt, 10 constant 4
//   o_alu_op       00 add, 01 sub, 10 decode funct3/funct7
//   o_result_src   00 ALUOut, 01 memory read data, 10 ALU result direct
//   o_illegal      high while parked in TRAP
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int IMM_SRC_W = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_instr,
  input  logic                 i_zero,
  input  logic                 i_mem_ready,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic                 o_adr_src,
  output logic                 o_ir_write,
  output logic                 o_pc_write,
  output logic                 o_reg_write,
  output logic [IMM_SRC_W-1:0] o_imm_src,
  output logic [1:0]           o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic [1:0]           o_alu_op,
  output logic [1:0]           o_result_src,
  output logic                 o_illegal
);

  // Immediate select encodings
  localparam logic [IMM_SRC_W-1:0] IMM_I    = IMM_SRC_W'(0);
  localparam logic [IMM_SRC_W-1:0] IMM_S    = IMM_SRC_W'(1);
  localparam logic [IMM_SRC_W-1:0] IMM_B    = IMM_SRC_W'(2);
  localparam logic [IMM_SRC_W-1:0] IMM_U    = IMM_SRC_W'(3);
  localparam logic [IMM_SRC_W-1:0] IMM_J    = IMM_SRC_W'(4);
  localparam logic [IMM_SRC_W-1:0] IMM_JALR = IMM_SRC_W'(5);

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operand / op / result encodings
  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_FUNC = 2'b10;
  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_MEM    = 2'b01;
  localparam logic [1:0] RS_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2,
    S_UIMM, S_TRAP
  } state_t;

  state_t r_state, w_next;

  // Last driven immediate select; replayed in states that do not use it.
  logic [IMM_SRC_W-1:0] r_imm_hold;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_unused_instr;

  assign w_opcode       = i_instr[6:0];
  assign w_funct3       = i_instr[14:12];
  assign w_unused_instr = ^{i_instr[31:15], i_instr[11:7]};

  // Raw decoded controls (before reset gating)
  logic                 w_mem_req, w_mem_we, w_adr_src, w_ir_write;
  logic                 w_pc_write, w_reg_write, w_illegal;
  logic                 w_imm_use;
  logic [IMM_SRC_W-1:0] w_imm_val;
  logic [1:0]           w_a, w_b, w_op, w_rs;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_imm_hold <= '0;
    end else begin
      r_state <= w_next;
      if (w_imm_use) r_imm_hold <= w_imm_val;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_adr_src   = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    w_imm_use   = 1'b0;
    w_imm_val   = IMM_I;
    w_a         = A_PC;
    w_b         = B_RS2;
    w_op        = OP_ADD;
    w_rs        = RS_ALUOUT;

    unique case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b0;
        if (i_mem_ready) begin
          // PC+4 goes straight back to PC from the ALU, bypassing ALUOut.
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_a        = A_PC;
          w_b        = B_FOUR;
          w_op       = OP_ADD;
          w_rs       = RS_ALU;
          w_next     = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculative target oldPC+imm into ALUOut; jal needs the J immediate.
        w_imm_use = 1'b1;
        w_imm_val = (w_opcode == OP_JAL) ? IMM_J : IMM_B;
        w_a       = A_OLDPC;
        w_b       = B_IMM;
        w_op      = OP_ADD;
        unique case (w_opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR1;
          OP_LUI, OP_AUIPC:  w_next = S_UIMM;
          default:           w_next = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        w_imm_use = 1'b1;
        w_imm_val = (w_opcode == OP_STORE) ? IMM_S : IMM_I;
        w_a       = A_RS1;
        w_b       = B_IMM;
        w_op      = OP_ADD;
        w_next    = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (i_mem_ready) w_next = S_MEMWB;
      end

      S_MEMWB: begin
        w_rs        = RS_MEM;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end

      S_MEMWRITE: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        w_adr_src = 1'b1;
        if (i_mem_ready) w_next = S_FETCH;
      end

      S_EXECR: begin
        w_a    = A_RS1;
        w_b    = B_RS2;
        w_op   = OP_FUNC;
        w_next = S_ALUWB;
      end

      S_EXECI: begin
        w_imm_use = 1'b1;
        w_imm_val = IMM_I;
        w_a       = A_RS1;
        w_b       = B_IMM;
        w_op      = OP_FUNC;
        w_next    = S_ALUWB;
      end

      S_ALUWB: begin
        w_rs        = RS_ALUOUT;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end

      S_BRANCH: begin
        // ALUOut still holds the DECODE target; the ALU compares rs1-rs2.
        w_a  = A_RS1;
        w_b  = B_RS2;
        w_op = OP_SUB;
        w_rs = RS_ALUOUT;
        unique case (w_funct3)
          3'b000: begin
            w_pc_write = i_zero;
            w_next     = S_FETCH;
          end
          3'b001: begin
            w_pc_write = ~i_zero;
            w_next     = S_FETCH;
          end
          default: w_next = S_TRAP;
        endcase
      end

      S_JAL: begin
        // PC <= ALUOut (target from DECODE); ALU forms oldPC+4 for rd.
        w_imm_use  = 1'b1;
        w_imm_val  = IMM_J;
        w_a        = A_OLDPC;
        w_b        = B_FOUR;
        w_op       = OP_ADD;
        w_rs       = RS_ALUOUT;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end

      S_JALR1: begin
        w_imm_use = 1'b1;
        w_imm_val = IMM_JALR;
        w_a       = A_RS1;
        w_b       = B_IMM;
        w_op      = OP_ADD;
        w_next    = S_JALR2;
      end

      S_JALR2: begin
        w_a        = A_OLDPC;
        w_b        = B_FOUR;
        w_op       = OP_ADD;
        w_rs       = RS_ALUOUT;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end

      S_UIMM: begin
        // LUI: 0 + imm, AUIPC: oldPC + imm
        w_imm_use = 1'b1;
        w_imm_val = IMM_U;
        w_a       = (w_opcode == OP_LUI) ? A_ZERO : A_OLDPC;
        w_b       = B_IMM;
        w_op      = OP_ADD;
        w_next    = S_ALUWB;
      end

      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end

      default: w_next = S_FETCH;
    endcase
  end

  // Output stage: everything is forced low during reset so that a reset
  // arriving mid-transaction cannot leak a PC/RF/memory write.
  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_imm_src    = '0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_result_src = 2'b00;
    o_illegal    = 1'b0;
    if (!i_rst) begin
      o_mem_req    = w_mem_req;
      o_mem_we     = w_mem_we;
      o_adr_src    = w_adr_src;
      o_ir_write   = w_ir_write;
      o_pc_write   = w_pc_write;
      o_reg_write  = w_reg_write;
      o_alu_src_a  = w_a;
      o_alu_src_b  = w_b;
      o_alu_op     = w_op;
      o_result_src = w_rs;
      o_illegal    = w_illegal;
      if (w_imm_use)
        o_imm_src = w_imm_val;
      else if (r_state != S_TRAP)
        o_imm_src = r_imm_hold;
    end
  end

endmodule
